// File: rtl/prach_pkg.sv
// Shared types and widths for the PRACH TDM sample bus.
package prach_pkg;

  localparam int unsigned NumLanes    = 3;
  localparam int unsigned SampleWidth = 16;
  localparam int unsigned ChnWidth    = 8;

  typedef struct packed {
    logic [SampleWidth-1:0] dr;
    logic [SampleWidth-1:0] di;
  } lane_sample_t;

  typedef lane_sample_t [NumLanes-1:0] tdm_word_t;

endpackage

// File: rtl/prach_tdm_fifo_ram.sv
// Simple dual-port sample store shared by all channel FIFOs, addressed {chn, ptr}.
// Reads are registered; a read and a write to the same address return the old word.
module prach_tdm_fifo_ram
  import prach_pkg::*;
#(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  tdm_word_t         wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output tdm_word_t         rdata
);

  localparam int unsigned Entries = NUM_CH * DEPTH;

  tdm_word_t mem [Entries];
  tdm_word_t rdata_d;
  tdm_word_t rdata_q;

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/prach_tdm_framer.sv
// Buffers channel-tagged samples per channel and replays them on a sync-aligned
// round-robin slot schedule with a fixed two-cycle output latency.
module prach_tdm_framer
  import prach_pkg::*;
#(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SampleWidth-1:0] din_dr [NumLanes],
  input  logic [SampleWidth-1:0] din_di [NumLanes],
  input  logic                   din_dv,
  input  logic [ChnWidth-1:0]    din_chn,
  input  logic                   sync_in,
  output logic [SampleWidth-1:0] dout_dr [NumLanes],
  output logic [SampleWidth-1:0] dout_di [NumLanes],
  output logic                   dout_dv,
  output logic [ChnWidth-1:0]    dout_chn,
  output logic                   sync_out,
  output logic [NUM_CH-1:0]      err_ovf,
  input  logic                   err_clr
);

  localparam int unsigned SlotW = $clog2(NUM_CH);
  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned AddrW = SlotW + PtrW;

  logic [SlotW-1:0]    s_d, s_q;
  logic [PtrW-1:0]     wr_ptr_d [NUM_CH];
  logic [PtrW-1:0]     wr_ptr_q [NUM_CH];
  logic [PtrW-1:0]     rd_ptr_d [NUM_CH];
  logic [PtrW-1:0]     rd_ptr_q [NUM_CH];
  logic [CntW-1:0]     cnt_d    [NUM_CH];
  logic [CntW-1:0]     cnt_q    [NUM_CH];
  logic                pop1_d, pop1_q;
  logic [SlotW-1:0]    chn1_d, chn1_q;
  logic                dout_dv_d, dout_dv_q;
  logic [ChnWidth-1:0] dout_chn_d, dout_chn_q;
  tdm_word_t           dout_word_d, dout_word_q;
  logic [2:0]          sync_pipe_d, sync_pipe_q;
  logic [NUM_CH-1:0]   err_d, err_q;

  logic [SlotW-1:0] wr_ch;
  logic             in_range;
  logic             pop;
  logic             wr_full;
  logic             wr_en;
  logic             ovf;
  tdm_word_t        din_word;
  tdm_word_t        ram_rdata;
  logic [AddrW-1:0] ram_waddr;
  logic [AddrW-1:0] ram_raddr;

  // Full is judged after this cycle's pop so a full FIFO being drained can still accept.
  assign wr_ch     = din_chn[SlotW-1:0];
  assign in_range  = din_dv && (din_chn < ChnWidth'(NUM_CH));
  assign pop       = (cnt_q[s_q] != '0);
  assign wr_full   = (cnt_q[wr_ch] == CntW'(DEPTH)) && !(pop && (s_q == wr_ch));
  assign wr_en     = in_range && !wr_full;
  assign ovf       = in_range && wr_full;
  assign ram_waddr = {wr_ch, wr_ptr_q[wr_ch]};
  assign ram_raddr = {s_q, rd_ptr_q[s_q]};

  always_comb begin
    for (int i = 0; i < NumLanes; i++) begin
      din_word[i].dr = din_dr[i];
      din_word[i].di = din_di[i];
    end
  end

  prach_tdm_fifo_ram #(
    .NUM_CH (NUM_CH),
    .DEPTH  (DEPTH),
    .ADDR_W (AddrW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (ram_waddr),
    .wdata (din_word),
    .re    (pop),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_comb begin
    s_d = (s_q == SlotW'(NUM_CH - 1)) ? '0 : s_q + SlotW'(1);
    if (sync_in) begin
      s_d = '0;
    end

    for (int c = 0; c < NUM_CH; c++) begin
      wr_ptr_d[c] = wr_ptr_q[c];
      rd_ptr_d[c] = rd_ptr_q[c];
      cnt_d[c]    = cnt_q[c]
                  + CntW'(wr_en && (wr_ch == SlotW'(c)))
                  - CntW'(pop && (s_q == SlotW'(c)));
      if (wr_en && (wr_ch == SlotW'(c))) begin
        wr_ptr_d[c] = wr_ptr_q[c] + PtrW'(1);
      end
      if (pop && (s_q == SlotW'(c))) begin
        rd_ptr_d[c] = rd_ptr_q[c] + PtrW'(1);
      end
    end

    // A new overflow outranks a simultaneous clear.
    err_d = err_q & ~{NUM_CH{err_clr}};
    if (ovf) begin
      err_d[wr_ch] = 1'b1;
    end

    pop1_d      = pop;
    chn1_d      = s_q;
    dout_dv_d   = pop1_q;
    dout_chn_d  = ChnWidth'(chn1_q);
    dout_word_d = pop1_q ? ram_rdata : '0;
    sync_pipe_d = {sync_pipe_q[1:0], sync_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q         <= '0;
      pop1_q      <= 1'b0;
      chn1_q      <= '0;
      dout_dv_q   <= 1'b0;
      dout_chn_q  <= '0;
      dout_word_q <= '0;
      sync_pipe_q <= '0;
      err_q       <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
      end
    end else begin
      s_q         <= s_d;
      pop1_q      <= pop1_d;
      chn1_q      <= chn1_d;
      dout_dv_q   <= dout_dv_d;
      dout_chn_q  <= dout_chn_d;
      dout_word_q <= dout_word_d;
      sync_pipe_q <= sync_pipe_d;
      err_q       <= err_d;
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        cnt_q[c]    <= cnt_d[c];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NumLanes; i++) begin
      dout_dr[i] = dout_word_q[i].dr;
      dout_di[i] = dout_word_q[i].di;
    end
  end

  assign dout_dv  = dout_dv_q;
  assign dout_chn = dout_chn_q;
  assign sync_out = sync_pipe_q[2];
  assign err_ovf  = err_q;

endmodule

// File: tb/tb_prach_tdm_framer.sv
// Directed bench for prach_tdm_framer: queue-based reference model checked every
// cycle, plus hand-computed expectations at the interesting cycles.
module tb_prach_tdm_framer;
  import prach_pkg::*;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned DEPTH  = 4;

  logic                   clk;
  logic                   rst;
  logic [SampleWidth-1:0] din_dr [NumLanes];
  logic [SampleWidth-1:0] din_di [NumLanes];
  logic                   din_dv;
  logic [ChnWidth-1:0]    din_chn;
  logic                   sync_in;
  logic [SampleWidth-1:0] dout_dr [NumLanes];
  logic [SampleWidth-1:0] dout_di [NumLanes];
  logic                   dout_dv;
  logic [ChnWidth-1:0]    dout_chn;
  logic                   sync_out;
  logic [NUM_CH-1:0]      err_ovf;
  logic                   err_clr;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  prach_tdm_framer #(.NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .din_dr   (din_dr),
    .din_di   (din_di),
    .din_dv   (din_dv),
    .din_chn  (din_chn),
    .sync_in  (sync_in),
    .dout_dr  (dout_dr),
    .dout_di  (dout_di),
    .dout_dv  (dout_dv),
    .dout_chn (dout_chn),
    .sync_out (sync_out),
    .err_ovf  (err_ovf),
    .err_clr  (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per-channel queues, slot index, two-deep output delay.
  tdm_word_t         mq [NUM_CH][$];
  int                m_s = 0;
  bit                m_pop;
  tdm_word_t         m_pw, m_in;
  bit                st1_dv = 0;
  logic [7:0]        st1_chn = '0;
  tdm_word_t         st1_word = '0;
  bit                m_sh1 = 0, m_sh2 = 0;
  bit                exp_dv = 0, exp_sync = 0;
  logic [7:0]        exp_chn = '0;
  tdm_word_t         exp_word = '0;
  logic [NUM_CH-1:0] exp_err = '0;

  always @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) mq[c].delete();
      m_s = 0; st1_dv = 0; st1_chn = '0; st1_word = '0;
      m_sh1 = 0; m_sh2 = 0;
      exp_dv = 0; exp_chn = '0; exp_word = '0; exp_sync = 0; exp_err = '0;
    end else begin
      exp_dv   = st1_dv;
      exp_chn  = st1_chn;
      exp_word = st1_dv ? st1_word : '0;
      m_pop = (mq[m_s].size() > 0);
      m_pw  = '0;
      if (m_pop) m_pw = mq[m_s].pop_front();
      st1_dv = m_pop; st1_chn = 8'(m_s); st1_word = m_pw;
      exp_err = exp_err & ~{NUM_CH{err_clr}};
      if (din_dv && din_chn < NUM_CH) begin
        for (int i = 0; i < NumLanes; i++) begin
          m_in[i].dr = din_dr[i];
          m_in[i].di = din_di[i];
        end
        if (mq[din_chn].size() < DEPTH) mq[din_chn].push_back(m_in);
        else exp_err[din_chn] = 1'b1;
      end
      exp_sync = m_sh2; m_sh2 = m_sh1; m_sh1 = sync_in;
      m_s = sync_in ? 0 : (m_s + 1) % NUM_CH;
    end
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    tdm_word_t got;
    for (int i = 0; i < NumLanes; i++) begin
      got[i].dr = dout_dr[i];
      got[i].di = dout_di[i];
    end
    check("model_dv",   96'(dout_dv),  96'(exp_dv));
    check("model_chn",  96'(dout_chn), 96'(exp_chn));
    check("model_data", 96'(got),      96'(exp_word));
    check("model_sync", 96'(sync_out), 96'(exp_sync));
    check("model_err",  96'(err_ovf),  96'(exp_err));
  endtask

  task automatic tick();
    @(negedge clk);
    if (chk_en) compare_model();
    @(posedge clk);
    #1;
    chk_en = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic idle_in();
    din_dv = 1'b0; sync_in = 1'b0; err_clr = 1'b0;
  endtask

  task automatic set_wr(input logic [7:0] ch, input logic [15:0] dr0, input logic [15:0] di0);
    din_dv  = 1'b1;
    din_chn = ch;
    for (int i = 0; i < NumLanes; i++) begin
      din_dr[i] = dr0 + 16'(i * 257);
      din_di[i] = di0 ^ 16'(i);
    end
  endtask

  // After this returns the current cycle has slot 0.
  task automatic do_sync();
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    din_chn = '0;
    for (int i = 0; i < NumLanes; i++) begin
      din_dr[i] = '0;
      din_di[i] = '0;
    end
    run(3);
    rst = 1'b0;

    // Idle after reset: slot numbers stream out two cycles behind the counter.
    check("rst_dv", 96'(dout_dv), 96'(0));
    check("rst_chn", 96'(dout_chn), 96'(0));
    run(2);
    for (int k = 0; k < 14; k++) begin
      check("idle_chn", 96'(dout_chn), 96'(k % 8));
      check("idle_dv", 96'(dout_dv), 96'(0));
      check("idle_dr0", 96'(dout_dr[0]), 96'(0));
      tick();
    end
    check("idle_err", 96'(err_ovf), 96'(0));

    // Sync then a single ch3 sample.
    do_sync();
    set_wr(8'd3, 16'h1234, 16'hABCD);
    tick();
    idle_in();
    check("sync_early", 96'(sync_out), 96'(0));
    tick();
    check("sync_out", 96'(sync_out), 96'(1));
    check("sync_chn", 96'(dout_chn), 96'(0));
    run(3);
    check("ch3_dv", 96'(dout_dv), 96'(1));
    check("ch3_chn", 96'(dout_chn), 96'(3));
    check("ch3_dr0", 96'(dout_dr[0]), 96'(16'h1234));
    check("ch3_di0", 96'(dout_di[0]), 96'(16'hABCD));
    check("ch3_dr2", 96'(dout_dr[2]), 96'(16'h1436));
    check("ch3_di2", 96'(dout_di[2]), 96'(16'hABCF));
    tick();
    check("ch3_after_dv", 96'(dout_dv), 96'(0));

    // Five writes to ch2 between its slots: the fifth overflows.
    do_sync();
    run(2);
    for (int k = 0; k < 5; k++) begin
      set_wr(8'd2, 16'h2000 + 16'(k * 16), 16'h5000 + 16'(k));
      tick();
    end
    idle_in();
    check("ch2_ovf", 96'(err_ovf), 96'(8'h04));
    run(5);
    for (int k = 0; k < 4; k++) begin
      check("ch2_dv", 96'(dout_dv), 96'(1));
      check("ch2_chn", 96'(dout_chn), 96'(2));
      check("ch2_dr0", 96'(dout_dr[0]), 96'(16'h2000 + 16'(k * 16)));
      run(8);
    end
    check("ch2_drop_dv", 96'(dout_dv), 96'(0));
    check("ch2_drop_chn", 96'(dout_chn), 96'(2));

    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_cleared", 96'(err_ovf), 96'(0));

    // Full ch5 written in its own slot: accepted because the slot pops.
    do_sync();
    for (int k = 0; k < 4; k++) begin
      set_wr(8'd5, 16'h5500 + 16'(k), 16'h0055);
      tick();
    end
    idle_in();
    tick();
    set_wr(8'd5, 16'h5504, 16'h0055);
    tick();
    idle_in();
    check("ch5_no_ovf", 96'(err_ovf), 96'(0));
    tick();
    check("ch5_first_dv", 96'(dout_dv), 96'(1));
    check("ch5_first_chn", 96'(dout_chn), 96'(5));
    check("ch5_first_dr0", 96'(dout_dr[0]), 96'(16'h5500));
    run(32);
    check("ch5_fifth_dv", 96'(dout_dv), 96'(1));
    check("ch5_fifth_dr0", 96'(dout_dr[0]), 96'(16'h5504));
    run(8);
    check("ch5_empty_dv", 96'(dout_dv), 96'(0));
    check("ch5_still_no_ovf", 96'(err_ovf), 96'(0));

    // Back-to-back sync pulses each give their own sync_out.
    sync_in = 1'b1;
    tick();
    tick();
    sync_in = 1'b0;
    tick();
    check("dsync_a", 96'(sync_out), 96'(1));
    check("dsync_a_chn", 96'(dout_chn), 96'(0));
    tick();
    check("dsync_b", 96'(sync_out), 96'(1));
    check("dsync_b_chn", 96'(dout_chn), 96'(0));
    tick();
    check("dsync_end", 96'(sync_out), 96'(0));

    // Out-of-range tags are ignored.
    set_wr(8'd8, 16'h8888, 16'h8888);
    tick();
    set_wr(8'd9, 16'h9999, 16'h9999);
    tick();
    idle_in();
    tick();
    check("oor_err", 96'(err_ovf), 96'(0));

    // ch0 overflow coinciding with err_clr: the set wins.
    do_sync();
    tick();
    for (int k = 0; k < 4; k++) begin
      set_wr(8'd0, 16'h0A00 + 16'(k), 16'h00A0);
      tick();
    end
    set_wr(8'd0, 16'h0A04, 16'h00A0);
    err_clr = 1'b1;
    tick();
    idle_in();
    check("clr_vs_set", 96'(err_ovf), 96'(8'h01));

    // Reset while several channels hold data discards everything.
    set_wr(8'd1, 16'h0101, 16'h0001);
    tick();
    set_wr(8'd4, 16'h0404, 16'h0004);
    tick();
    set_wr(8'd6, 16'h0606, 16'h0006);
    tick();
    idle_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("post_rst_err", 96'(err_ovf), 96'(0));
    for (int k = 0; k < 20; k++) begin
      check("post_rst_dv", 96'(dout_dv), 96'(0));
      tick();
    end
    set_wr(8'd1, 16'h1111, 16'h2222);
    tick();
    idle_in();
    run(6);
    check("resume_dv", 96'(dout_dv), 96'(1));
    check("resume_chn", 96'(dout_chn), 96'(1));
    check("resume_dr0", 96'(dout_dr[0]), 96'(16'h1111));
    run(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
